gb_alu_issue: RTL

Issue/writeback sequencer that drives the `alu8` datapath. It owns the accumulator A and flag register F. It accepts one Game Boy 8-bit arithmetic/logic instruction at a time, gathers the source operand, presents operands to `alu8` for one execute cycle, then writes A and F back. Operands come from the register file, an immediate, or a memory read at (HL). It sits between the instruction decoder and `alu8` in the CPU core.

---
 rtl/gb_alu_pkg.sv | 46 ++++
 rtl/alu8.sv | 66 ++++++
 rtl/gb_alu_issue.sv | 139 +++++++++++++
 3 files changed

// File: rtl/gb_alu_pkg.sv
// Shared definitions for the Game Boy 8-bit ALU datapath and its issue sequencer.
// Holds alu8 opcodes, flag bit positions, the sequencer state enum and decode helpers.
package gb_alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_ADC  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_SBC  = 4'd3;
    localparam logic [3:0] OP_CP   = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_INC  = 4'd8;
    localparam logic [3:0] OP_DEC  = 4'd9;
    localparam logic [3:0] OP_SWAP = 4'd10;

    localparam int FLAG_Z = 7;
    localparam int FLAG_N = 6;
    localparam int FLAG_H = 5;
    localparam int FLAG_C = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_EXEC = 2'd2
    } state_e;

    // Opcode bits [5:3] select the arithmetic group; note XOR/OR order differs from alu8 numbering.
    function automatic logic [3:0] group_to_op(input logic [2:0] grp);
        case (grp)
            3'd0:    return OP_ADD;
            3'd1:    return OP_ADC;
            3'd2:    return OP_SUB;
            3'd3:    return OP_SBC;
            3'd4:    return OP_AND;
            3'd5:    return OP_XOR;
            3'd6:    return OP_OR;
            default: return OP_CP;
        endcase
    endfunction

    function automatic logic inst_legal(input logic [7:0] inst);
        return (inst[7:6] == 2'b10) || (inst[7:6] == 2'b11 && inst[2:0] == 3'b110);
    endfunction

endpackage

// File: rtl/alu8.sv
// Combinational Game Boy 8-bit ALU: result plus ZNHC flags in bits [7:4].
module alu8
    import gb_alu_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] op,
    input  logic       cin,
    output logic [7:0] res,
    output logic [7:0] flags
);

    logic [8:0] wide;
    logic [4:0] half;
    logic       c_use;
    logic       n_f, h_f, c_f;

    always_comb begin
        c_use = cin & ((op == OP_ADC) | (op == OP_SBC));
        wide  = 9'd0;
        half  = 5'd0;
        res   = a;
        n_f   = 1'b0;
        h_f   = 1'b0;
        c_f   = 1'b0;
        case (op)
            OP_ADD, OP_ADC: begin
                wide = {1'b0, a} + {1'b0, b} + 9'(c_use);
                half = {1'b0, a[3:0]} + {1'b0, b[3:0]} + 5'(c_use);
                res  = wide[7:0];
                h_f  = half[4];
                c_f  = wide[8];
            end
            // Borrows show up as the wrap into bit 8 / bit 4 of the widened difference.
            OP_SUB, OP_SBC, OP_CP: begin
                wide = {1'b0, a} - {1'b0, b} - 9'(c_use);
                half = {1'b0, a[3:0]} - {1'b0, b[3:0]} - 5'(c_use);
                res  = wide[7:0];
                n_f  = 1'b1;
                h_f  = half[4];
                c_f  = wide[8];
            end
            OP_AND: begin
                res = a & b;
                h_f = 1'b1;
            end
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_INC: begin
                res = a + 8'd1;
                h_f = (a[3:0] == 4'hF);
                c_f = cin;
            end
            OP_DEC: begin
                res = a - 8'd1;
                n_f = 1'b1;
                h_f = (a[3:0] == 4'h0);
                c_f = cin;
            end
            OP_SWAP: res = {a[3:0], a[7:4]};
            default: res = a;
        endcase
        flags = {(res == 8'd0), n_f, h_f, c_f, 4'b0000};
    end

endmodule

// File: rtl/gb_alu_issue.sv
// Issue/writeback sequencer for 8-bit ALU instructions: gathers the operand,
// runs one alu8 execute cycle, then writes back A and F.
module gb_alu_issue
    import gb_alu_pkg::*;
#(
    parameter logic [7:0] A_RESET = 8'h01,
    parameter logic [7:0] F_RESET = 8'hB0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_inst,
    input  logic [7:0]  in_imm,
    output logic [2:0]  rf_sel,
    input  logic [7:0]  rf_data,
    input  logic [15:0] hl,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_op,
    output logic        alu_cin,
    input  logic [7:0]  alu_res,
    input  logic [7:0]  alu_flags,
    output logic [7:0]  a_out,
    output logic [7:0]  f_out,
    output logic        done,
    output logic        illegal
);

    localparam logic [7:0] F_INIT = {F_RESET[7:4], 4'b0000};

    state_e      state_q, state_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  f_q, f_d;
    logic [7:0]  opnd_q, opnd_d;
    logic [3:0]  op_q, op_d;
    logic        cin_q, cin_d;
    logic [15:0] addr_q, addr_d;
    logic        done_q, done_d;
    logic        illegal_q, illegal_d;
    logic        unused_flags;

    assign unused_flags = ^alu_flags[3:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            a_q       <= A_RESET;
            f_q       <= F_INIT;
            opnd_q    <= 8'd0;
            op_q      <= OP_ADD;
            cin_q     <= 1'b0;
            addr_q    <= 16'd0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            f_q       <= f_d;
            opnd_q    <= opnd_d;
            op_q      <= op_d;
            cin_q     <= cin_d;
            addr_q    <= addr_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        f_d       = f_q;
        opnd_d    = opnd_q;
        op_d      = op_q;
        cin_d     = cin_q;
        addr_d    = addr_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (!inst_legal(in_inst)) begin
                        illegal_d = 1'b1;
                    end else begin
                        op_d  = group_to_op(in_inst[5:3]);
                        cin_d = f_q[FLAG_C];
                        if (in_inst[7:6] == 2'b11) begin
                            opnd_d  = in_imm;
                            state_d = ST_EXEC;
                        end else if (in_inst[2:0] == 3'd6) begin
                            addr_d  = hl;
                            state_d = ST_MEM;
                        end else if (in_inst[2:0] == 3'd7) begin
                            opnd_d  = a_q;
                            state_d = ST_EXEC;
                        end else begin
                            opnd_d  = rf_data;
                            state_d = ST_EXEC;
                        end
                    end
                end
            end
            ST_MEM: begin
                if (mem_ack) begin
                    opnd_d  = mem_rdata;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // CP only produces flags; the accumulator keeps its value.
                if (op_q != OP_CP) begin
                    a_d = alu_res;
                end
                f_d     = {alu_flags[7:4], 4'b0000};
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_ready = (state_q == ST_IDLE);
    assign rf_sel   = in_inst[2:0];
    assign mem_req  = (state_q == ST_MEM);
    assign mem_addr = addr_q;
    assign alu_a    = a_q;
    assign alu_b    = opnd_q;
    assign alu_op   = op_q;
    assign alu_cin  = cin_q;
    assign a_out    = a_q;
    assign f_out    = f_q;
    assign done     = done_q;
    assign illegal  = illegal_q;

endmodule
